// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Rebuilds four channels (A-D) from a sync-framed TDM stream.
//               HUNT/LOCKED alignment; frames are published all at once.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             frame_valid,
  output logic             sync_err,
  output logic [1:0]       slot
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] sh0_q, sh0_d;
  logic [WIDTH-1:0] sh1_q, sh1_d;
  logic [WIDTH-1:0] sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             fv_q, fv_d;
  logic             se_q, se_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            sh0_d   = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          // Misplaced sync realigns: partial frame is dropped, sample becomes slot 0.
          if (sync && (slot_q != 2'd0)) begin
            se_d   = 1'b1;
            sh0_d  = din;
            slot_d = 2'd1;
          end else begin
            case (slot_q)
              2'd0: sh0_d = din;
              2'd1: sh1_d = din;
              2'd2: sh2_d = din;
              2'd3: begin
                a_d  = sh0_q;
                b_d  = sh1_q;
                c_d  = sh2_q;
                d_d  = din;
                fv_d = 1'b1;
              end
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign slot        = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Self-checking bench for tdm_demux4 against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] A, B, C, D;
  logic         frame_valid;
  logic         sync_err;
  logic [1:0]   slot;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: aligned flag plus the samples collected for the current frame.
  bit           m_locked;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_out[4];
  bit           m_fv;
  bit           m_se;

  tdm_demux4 #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .slot       (slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_edge(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1'b1;
          m_q.delete();
          m_q.push_back(d);
        end
      end else if (s && m_q.size() != 0) begin
        m_se = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, update the model, then compare.
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst = r; din_valid = v; sync = s; din = d;
    @(posedge clk);
    model_edge(r, v, s, d);
    #1;
    chk("A", 32'(A), 32'(m_out[0]));
    chk("B", 32'(B), 32'(m_out[1]));
    chk("C", 32'(C), 32'(m_out[2]));
    chk("D", 32'(D), 32'(m_out[3]));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    chk("slot", 32'(slot), 32'(m_q.size()));
  endtask

  task automatic chk_frame(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, "_A"}, 32'(A), 32'(a));
    chk({tag, "_B"}, 32'(B), 32'(b));
    chk({tag, "_C"}, 32'(C), 32'(c));
    chk({tag, "_D"}, 32'(D), 32'(d));
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;
    m_locked = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = '0;

    // Reset, then idle cycles.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk_frame("idle", 0, 0, 0, 0);
      chk("idle_slot", 32'(slot), 0);
      chk("idle_fv", 32'(frame_valid), 0);
    end

    // Contiguous frame 1,0,1,1.
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("f1_fv", 32'(frame_valid), 1);
    chk_frame("f1", 1, 0, 1, 1);
    step(0, 0, 0, 0);
    chk("f1_fv_drop", 32'(frame_valid), 0);

    // Hunt: unsynced samples dropped before alignment.
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("hunt_slot", 32'(slot), 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_frame("hunt", 0, 1, 0, 0);

    // Misplaced sync while locked.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    chk("resync_err", 32'(sync_err), 1);
    chk_frame("resync_hold", 0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("resync_err_drop", 32'(sync_err), 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk("resync_fv", 32'(frame_valid), 1);
    chk_frame("resync", 0, 0, 1, 1);

    // Gapped frame 1,0,1,0 with two idle cycles between samples.
    step(0, 1, 1, 1);
    step(0, 0, 0, 0); step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 1);
    chk("gap_slot", 32'(slot), 2);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk_frame("gap", 1, 0, 1, 0);

    // Reset mid-frame, then a full frame of ones.
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    chk_frame("rstmid", 0, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    chk_frame("rstmid_partial", 0, 0, 0, 0);
    step(0, 1, 0, 1);
    chk_frame("rstmid_full", 1, 1, 1, 1);

    // Back-to-back frames at full rate.
    for (int i = 0; i < 16; i++) step(0, 1, (i % 4) == 0, W'($urandom_range(0, 15)));

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0,
           W'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each sample and each channel output.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: din  input  WIDTH  time-division-multiplexed sample stream (channel order A, B, C, D).
REQ-005 Port: din_valid  input  1  din carries a sample this cycle.
REQ-006 Port: sync  input  1  qualified by din_valid; marks the slot-0 (channel A) sample of a frame.
REQ-007 Port: A  output  WIDTH  last completed frame, slot 0.
REQ-008 Port: B  output  WIDTH  last completed frame, slot 1.
REQ-009 Port: C  output  WIDTH  last completed frame, slot 2.
REQ-010 Port: D  output  WIDTH  last completed frame, slot 3.
REQ-011 Port: frame_valid  output  1  one-cycle pulse: A-D were just updated with a new frame.
REQ-012 Port: sync_err  output  1  one-cycle pulse: sync seen at a slot other than 0.
REQ-013 Port: slot  output  2  index of the slot the next accepted sample fills.

Function
REQ-014 The block SHALL be the receive-side counterpart of a 4:1 mux: it rebuilds 4 channels from a serial stream.
REQ-015 The block SHALL have two states: HUNT (not aligned) and LOCKED (aligned).
REQ-016 The block SHALL ignore any cycle with din_valid=0; state, slot and shadow registers hold.
REQ-017 In HUNT, samples with sync=0 SHALL be discarded, with no output change.
REQ-018 In HUNT, a sample with sync=1 SHALL be stored to shadow slot 0, set slot=1, and enter LOCKED.
REQ-019 In LOCKED, each accepted sample SHALL be stored to shadow[slot], and slot SHALL increment modulo 4.
REQ-020 In LOCKED, a slot-0 sample with sync=0 SHALL be accepted normally (flywheel); no error.
REQ-021 In LOCKED, a sample with sync=1 at slot≠0 SHALL pulse sync_err, discard the partial frame, store the sample as slot 0, and set slot=1.
REQ-022 On the edge accepting the slot-3 sample, A-D SHALL load shadow slots 0-2 plus that sample together, and slot SHALL wrap to 0.
REQ-023 frame_valid SHALL be 1 for exactly the cycle following that edge; latency is 1 clock from slot-3 sample to outputs.
REQ-024 A-D SHALL hold their values between frames; a partial or discarded frame SHALL never reach A-D.
REQ-025 Back-to-back frames with din_valid=1 every cycle SHALL be sustained with no gap: one frame_valid every 4 cycles.
REQ-026 sync_err and frame_valid SHALL NOT both assert for the same sample.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL enter HUNT, and slot, shadow and A-D SHALL become 0.
REQ-028 While rst=1 at a rising edge, frame_valid and sync_err SHALL become 0.
REQ-029 rst SHALL take priority over din_valid on the same edge.
REQ-030 Reset mid-frame SHALL discard the partial frame; A-D read 0 until the next full frame.

Verification
REQ-031 Reset, then 3 cycles of din_valid=0 -> A-D=0, slot=0, frame_valid=0, sync_err=0 throughout.
REQ-032 WIDTH=1, stream 1(sync),0,1,1 on consecutive cycles -> A=1, B=0, C=1, D=1; frame_valid high for one cycle after the 4th edge.
REQ-033 In HUNT, samples 1,1 without sync, then 0(sync),1,0,0 -> A=0, B=1, C=0, D=0; the leading samples are ignored.
REQ-034 LOCKED: 1(sync),1, then 0(sync),0,1,1 -> sync_err pulses once at the 3rd sample; the frame A=0, B=0, C=1, D=1 is published; the prior frame's A-D are unchanged until then.
REQ-035 Frame 1,0,1,0 with din_valid low for 2 cycles between samples -> same result as contiguous; slot holds during gaps.
REQ-036 rst asserted after 2 samples of a frame, then frame 1(sync),1,1,1 -> A-D stay 0 until it completes, then all =1.
